pb_event_decoder: RTL
=====================

# pb_event_decoder

Consumes the one-cycle press/release pulses from the push-button debouncer and classifies each gesture as a short press, long press or double press. Events go out as one-cycle pulses and through a one-deep valid/ready event register for the front-panel mode controller. Sits directly downstream of the debouncer in the recorder's user-input path.

## Interface

Parameters:
- `CLK_DIV`, default 1000: clk cycles per timing tick, ≥ 2.
- `LONG_TICKS`, default 500: hold length, in ticks, that makes a long press, ≥ 2.
- `DOUBLE_TICKS`, default 250: maximum release-to-second-press gap, in ticks, for a double press, ≥ 2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `pb_down`  in  1  one-cycle debounced press pulse.
- `pb_up`  in  1  one-cycle debounced release pulse.
- `short_press`  out  1  one-cycle pulse.
- `long_press`  out  1  one-cycle pulse.
- `double_press`  out  1  one-cycle pulse.
- `ev_valid`  out  1  event register holds an unconsumed event.
- `ev_code`  out  2  1 = short, 2 = long, 3 = double, 0 = none.
- `ev_ready`  in  1  consumer accepts `ev_code` when `ev_valid & ev_ready`.
- `ev_overflow`  out  1  sticky: an event was dropped.
- `busy`  out  1  FSM not in IDLE.

## Operation

- FSM states: IDLE, HELD1, GAP, HELD2, LONGHELD.
- IDLE:
  - `pb_down` → HELD1, timer cleared.
  - `pb_up` is ignored. A button held through reset is never classified.
- HELD1:
  - `pb_up` → GAP, timer cleared.
  - Timer reaches `LONG_TICKS` → emit long, then LONGHELD.
- LONGHELD:
  - `pb_up` → IDLE.
  - No further events while in this state.
- GAP:
  - `pb_down` → emit double, then HELD2.
  - Timer reaches `DOUBLE_TICKS` → emit short, then IDLE.
- HELD2:
  - `pb_up` → IDLE.
  - No long-press detection, regardless of hold length.
- Timer:
  - Prescaler 0..`CLK_DIV`-1 plus tick counter.
  - Both cleared on every state entry and held cleared in IDLE.
  - The tick counter saturates at the active threshold.
- Widths: `$clog2(CLK_DIV)` for the prescaler, `$clog2(max(LONG_TICKS, DOUBLE_TICKS)+1)` for the tick counter. No wrap-around is allowed.
- Emitting an event does two things in the same cycle:
  - pulses the matching output;
  - loads the event register with the matching `ev_code`, setting `ev_valid`.
- Event register:
  - If `ev_valid & ~ev_ready` at load time, the new event is dropped, `ev_overflow` is set and the held event is kept.
  - If `ev_valid & ev_ready` at load time, the new event replaces the held one with no drop.
  - On handshake with no new event, `ev_valid` goes to 0 and `ev_code` to 0.
- Simultaneous events:
  - HELD1: `pb_up` together with long threshold → `pb_up` wins, so it is a short-path gesture.
  - GAP: `pb_down` together with gap timeout → `pb_down` wins, so it is a double.
  - `pb_down` and `pb_up` in the same cycle: take the transition relevant to the current state, ignore the other.
- Reset, at any time including mid-gesture: state IDLE, timer 0, all outputs 0, `ev_overflow` cleared.

## Timing

- All outputs are registered. Reset value of every output is 0.
- Cycle numbering: `pb_down`/`pb_up` are sampled at edge 0. The state change is visible after edge 0.
- Long press: `long_press` is high in the cycle following edge `LONG_TICKS*CLK_DIV` after the `pb_down` edge. Exact, with no tick quantization, because the timer restarts on state entry.
- Short press: `short_press` is high in the cycle following edge `DOUBLE_TICKS*CLK_DIV` after the first `pb_up` edge.
- Double press: `double_press` is high in the cycle after the second `pb_down` is sampled (1-cycle latency).
- Event register: `ev_valid` rises in the same cycle as the pulse. It falls in the cycle after the `ev_valid & ev_ready` edge.
- `ev_overflow` rises in the cycle after the dropped load.

## Structure

- Package `pb_event_pkg` holds:
  - the state encoding (IDLE = 0, HELD1, GAP, HELD2, LONGHELD);
  - the event codes (`EV_NONE` = 0, `EV_SHORT` = 1, `EV_LONG` = 2, `EV_DOUBLE` = 3).
- Sub-module `pb_tick_timer`:
  - parameter `CLK_DIV`;
  - inputs `clear` and `limit`;
  - output `expired`, which rises when the tick count equals `limit`.
- The FSM and event register live in the top module.

## Test plan

Benches use `CLK_DIV`=4, `LONG_TICKS`=10, `DOUBLE_TICKS`=5.

1. Short press: `pb_down`, then `pb_up` 8 cycles later, no further input → `short_press` exactly 20 cycles after `pb_up`; `ev_code`=1.
2. Long press: `pb_down`, hold 100 cycles → `long_press` exactly 40 cycles after `pb_down`. A later `pb_up` → no event; `busy` drops.
3. Double press: down, up at +8, down 12 cycles after up → `double_press` 1 cycle after second down; `ev_code`=3. Holding 100 cycles gives no long press.
4. Boundaries:
   - `pb_up` on the long-threshold cycle → short, not long.
   - Second `pb_down` on the gap-timeout cycle → double.
5. Handshake and overflow:
   - Hold `ev_ready`=0 and produce two shorts → first code kept, `ev_overflow`=1.
   - Then `ev_ready`=1 → `ev_valid` falls the next cycle.
6. Reset:
   - Assert `rst` mid-HELD1 → all outputs 0, IDLE.
   - Following `pb_up` → ignored, no event.

Source files
------------

// File: rtl/pb_event_pkg.sv
// pb_event_pkg
//   Shared definitions for the push-button event decoder:
//   - the FSM state encoding;
//   - the event codes carried on ev_code;
//   - a small integer helper used to size the tick counter.
package pb_event_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HELD1    = 3'd1,
    ST_GAP      = 3'd2,
    ST_HELD2    = 3'd3,
    ST_LONGHELD = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_SHORT  = 2'd1,
    EV_LONG   = 2'd2,
    EV_DOUBLE = 2'd3
  } ev_code_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pb_tick_timer.sv
// pb_tick_timer
//   Prescaler (0..CLK_DIV-1) feeding a saturating tick counter.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     clear     : zero prescaler and tick counter this cycle
//     limit     : tick count at which the timer expires
//     expired   : high in the cycle whose clock edge brings the tick count to
//                 limit, and held while the count sits saturated at limit.
//                 The look-ahead lets a registered consumer act on exactly the
//                 edge where the count reaches limit.
module pb_tick_timer #(
  parameter int CLK_DIV = 1000,
  parameter int TICK_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [TICK_W-1:0] limit,
  output logic              expired
);

  localparam int PRE_W = $clog2(CLK_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1);
  localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);

  logic [PRE_W-1:0]  presc;
  logic [TICK_W-1:0] ticks;
  logic              tick_now;
  logic              saturated;

  assign tick_now  = (presc == PRE_LAST);
  assign saturated = (ticks == limit);

  // Once saturated both counters freeze, so neither can wrap.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      presc <= '0;
      ticks <= '0;
    end else if (!saturated) begin
      if (tick_now) begin
        presc <= '0;
        ticks <= ticks + TICK_ONE;
      end else begin
        presc <= presc + PRE_ONE;
      end
    end
  end

  assign expired = saturated || (tick_now && (ticks == (limit - TICK_ONE)));

endmodule

// File: rtl/pb_event_decoder.sv
// pb_event_decoder
//   Classifies debounced press/release pulses into short, long and double
//   presses.
//   Ports:
//     clk, rst       : clock, synchronous active-high reset
//     pb_down, pb_up : one-cycle debounced press / release pulses
//     short_press, long_press, double_press : registered one-cycle event pulses
//     ev_valid, ev_code, ev_ready : one-deep event register towards the consumer
//     ev_overflow    : sticky, an event was dropped because the register was full
//     busy           : FSM is not idle
//     state_dbg      : current FSM state, for observation only
//
//   Event handshake: ev_code is transferred on any clock edge where
//   ev_valid & ev_ready. ev_valid holds, with ev_code stable, until that edge.
//   A new event arriving while the register is full and not being accepted is
//   dropped and sets ev_overflow. A new event arriving on an accepting edge
//   replaces the accepted one.
module pb_event_decoder
  import pb_event_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int LONG_TICKS   = 500,
  parameter int DOUBLE_TICKS = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb_down,
  input  logic       pb_up,
  output logic       short_press,
  output logic       long_press,
  output logic       double_press,
  output logic       ev_valid,
  output logic [1:0] ev_code,
  input  logic       ev_ready,
  output logic       ev_overflow,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int TICK_W = $clog2(max_int(LONG_TICKS, DOUBLE_TICKS) + 1);
  localparam logic [TICK_W-1:0] LONG_LIM = TICK_W'(LONG_TICKS);
  localparam logic [TICK_W-1:0] DBL_LIM  = TICK_W'(DOUBLE_TICKS);

  state_t            state;
  state_t            next_state;
  ev_code_t          ev_new;
  ev_code_t          ev_code_q;
  logic              timer_clear;
  logic [TICK_W-1:0] timer_limit;
  logic              expired;

  // The timer restarts on every state entry, so thresholds are measured
  // exactly from the edge that entered the state.
  assign timer_clear = (state == ST_IDLE) || (next_state != state);
  assign timer_limit = (state == ST_GAP) ? DBL_LIM : LONG_LIM;

  pb_tick_timer #(
    .CLK_DIV (CLK_DIV),
    .TICK_W  (TICK_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .limit   (timer_limit),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic. Button edges take priority over timer expiry.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (pb_down) next_state = ST_HELD1;
      ST_HELD1: begin
        if (pb_up)        next_state = ST_GAP;
        else if (expired) next_state = ST_LONGHELD;
      end
      ST_GAP: begin
        if (pb_down)      next_state = ST_HELD2;
        else if (expired) next_state = ST_IDLE;
      end
      ST_HELD2:    if (pb_up) next_state = ST_IDLE;
      ST_LONGHELD: if (pb_up) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Output logic: event emitted on the transition edge
  always_comb begin
    ev_new = EV_NONE;
    case (state)
      ST_HELD1: if (!pb_up && expired) ev_new = EV_LONG;
      ST_GAP: begin
        if (pb_down)      ev_new = EV_DOUBLE;
        else if (expired) ev_new = EV_SHORT;
      end
      default: ev_new = EV_NONE;
    endcase
  end

  // Registered pulses and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      busy         <= 1'b0;
    end else begin
      short_press  <= (ev_new == EV_SHORT);
      long_press   <= (ev_new == EV_LONG);
      double_press <= (ev_new == EV_DOUBLE);
      busy         <= (next_state != ST_IDLE);
    end
  end

  // One-deep event register
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid    <= 1'b0;
      ev_code_q   <= EV_NONE;
      ev_overflow <= 1'b0;
    end else if (ev_new != EV_NONE) begin
      if (ev_valid && !ev_ready) begin
        ev_overflow <= 1'b1;
      end else begin
        ev_valid  <= 1'b1;
        ev_code_q <= ev_new;
      end
    end else if (ev_valid && ev_ready) begin
      ev_valid  <= 1'b0;
      ev_code_q <= EV_NONE;
    end
  end

  assign ev_code   = ev_code_q;
  assign state_dbg = state;

endmodule
